// File: rtl/div_iter_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : div_iter_ctrl
// Description : Iterative radix-2 restoring divider with its EX-stage
//               sequencer for div.w / div.wu / mod.w / mod.wu. One request is
//               accepted from ES. The divider then runs WIDTH iterations while
//               holding IS/ES through div_stall. It returns a registered
//               quotient or remainder with a one-cycle div_done pulse. A
//               flush aborts an in-flight divide.
// Ports       : clk        - clock, all state on rising edge
//               reset      - asynchronous active-high reset
//               div_req    - ES holds a valid divide (level, held while stalled)
//               div_signed - 1: signed (div.w/mod.w), 0: unsigned
//               div_mod    - 1: return remainder, 0: return quotient
//               div_src1   - dividend
//               div_src2   - divisor
//               flush      - kill in-flight divide
//               div_stall  - combinational stall to hazard unit
//               div_done   - registered one-cycle result-valid pulse
//               div_result - registered quotient/remainder, held until next done
// Config      : DIV_FAST_ZERO_EN - when defined, a divide by zero skips the
//               iterations and completes one cycle after acceptance.
// Revision    : 1.0 - initial release
// ============================================================================
module div_iter_ctrl #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             div_req,
    input  logic             div_signed,
    input  logic             div_mod,
    input  logic [WIDTH-1:0] div_src1,
    input  logic [WIDTH-1:0] div_src2,
    input  logic             flush,
    output logic             div_stall,
    output logic             div_done,
    output logic [WIDTH-1:0] div_result
);

    localparam int              CW       = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0]   LAST_CNT = CW'(WIDTH - 1);
    localparam logic [WIDTH-1:0] ONE     = {{(WIDTH-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] rem_q, rem_d;       // partial remainder
    logic [WIDTH-1:0] quo_q, quo_d;       // dividend bits shift out MSB, quotient bits shift in LSB
    logic [WIDTH-1:0] dvs_q, dvs_d;       // divisor magnitude
    logic [WIDTH-1:0] src1_q, src1_d;     // raw dividend, returned as remainder on divide by zero
    logic [WIDTH-1:0] result_q, result_d;
    logic             s1_q, s1_d;
    logic             s2_q, s2_d;
    logic             sgn_q, sgn_d;
    logic             mod_q, mod_d;
    logic             zero_q, zero_d;
    logic             done_q, done_d;

    function automatic logic [WIDTH-1:0] negate(input logic [WIDTH-1:0] x);
        return ~x + ONE;
    endfunction

    // Operand magnitudes at acceptance
    logic [WIDTH-1:0] a_mag, b_mag;
    logic             b_zero;
    assign a_mag  = (div_signed & div_src1[WIDTH-1]) ? negate(div_src1) : div_src1;
    assign b_mag  = (div_signed & div_src2[WIDTH-1]) ? negate(div_src2) : div_src2;
    assign b_zero = (div_src2 == '0);

    // One restoring step. The trial difference is WIDTH+1 bits wide, so its
    // MSB is the borrow. The kept remainder is always below the divisor and
    // therefore fits back into WIDTH bits.
    logic [WIDTH:0]   shifted, trial;
    logic             qbit;
    logic [WIDTH-1:0] rem_step, quo_step;
    assign shifted  = {rem_q, quo_q[WIDTH-1]};
    assign trial    = shifted - {1'b0, dvs_q};
    assign qbit     = ~trial[WIDTH];
    assign rem_step = qbit ? trial[WIDTH-1:0] : shifted[WIDTH-1:0];
    assign quo_step = {quo_q[WIDTH-2:0], qbit};

    // Signed fix-up of the final step. The divide-by-zero values bypass it.
    logic [WIDTH-1:0] final_val;
    always_comb begin
        final_val = quo_step;
        if (zero_q) begin
            final_val = mod_q ? src1_q : '1;
        end else if (mod_q) begin
            final_val = (sgn_q & s1_q) ? negate(rem_step) : rem_step;
        end else begin
            final_val = (sgn_q & (s1_q ^ s2_q)) ? negate(quo_step) : quo_step;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        rem_d    = rem_q;
        quo_d    = quo_q;
        dvs_d    = dvs_q;
        src1_d   = src1_q;
        s1_d     = s1_q;
        s2_d     = s2_q;
        sgn_d    = sgn_q;
        mod_d    = mod_q;
        zero_d   = zero_q;
        done_d   = 1'b0;
        result_d = result_q;

        case (state_q)
            S_IDLE: begin
                if (div_req & ~flush) begin
                    cnt_d  = '0;
                    rem_d  = '0;
                    quo_d  = a_mag;
                    dvs_d  = b_mag;
                    src1_d = div_src1;
                    s1_d   = div_src1[WIDTH-1];
                    s2_d   = div_src2[WIDTH-1];
                    sgn_d  = div_signed;
                    mod_d  = div_mod;
                    zero_d = b_zero;
`ifdef DIV_FAST_ZERO_EN
                    if (b_zero) begin
                        state_d  = S_DONE;
                        done_d   = 1'b1;
                        result_d = div_mod ? div_src1 : '1;
                    end else begin
                        state_d = S_CALC;
                    end
`else
                    state_d = S_CALC;
`endif
                end
            end
            S_CALC: begin
                rem_d = rem_step;
                quo_d = quo_step;
                if (cnt_q == LAST_CNT) begin
                    state_d  = S_DONE;
                    done_d   = 1'b1;
                    result_d = final_val;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_DONE: begin
                // div_req here belongs to the completing instruction
                state_d = S_IDLE;
                cnt_d   = '0;
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase

        // A flush overrides everything: no completion, result untouched
        if (flush) begin
            state_d  = S_IDLE;
            cnt_d    = '0;
            done_d   = 1'b0;
            result_d = result_q;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            rem_q    <= '0;
            quo_q    <= '0;
            dvs_q    <= '0;
            src1_q   <= '0;
            s1_q     <= 1'b0;
            s2_q     <= 1'b0;
            sgn_q    <= 1'b0;
            mod_q    <= 1'b0;
            zero_q   <= 1'b0;
            done_q   <= 1'b0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            rem_q    <= rem_d;
            quo_q    <= quo_d;
            dvs_q    <= dvs_d;
            src1_q   <= src1_d;
            s1_q     <= s1_d;
            s2_q     <= s2_d;
            sgn_q    <= sgn_d;
            mod_q    <= mod_d;
            zero_q   <= zero_d;
            done_q   <= done_d;
            result_q <= result_d;
        end
    end

    assign div_stall  = ~flush & ((div_req & (state_q == S_IDLE)) | (state_q == S_CALC));
    assign div_done   = done_q;
    assign div_result = result_q;

endmodule
`default_nettype wire
